// File: rtl/nary_gate_sweep_pkg.sv
// Shared definitions for the N-input gate evaluator and truth-table sweeper:
// op encodings, FSM states and the supported input-count range.
package nary_gate_sweep_pkg;

    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/nary_gate_sweep_gate_eval.sv
// Combinational N-input gate: reductions for AND/OR families, parity for XOR/XNOR.
// Unknown ops give 0 and raise o_illegal.
module gate_eval
    import nary_gate_sweep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] i_operand,
    input  logic [2:0]   i_op,
    output logic         o_result,
    output logic         o_illegal
);

    always_comb begin
        o_result  = 1'b0;
        o_illegal = 1'b0;
        case (i_op)
            OP_AND:  o_result = &i_operand;
            OP_OR:   o_result = |i_operand;
            OP_NAND: o_result = ~&i_operand;
            OP_NOR:  o_result = ~|i_operand;
            OP_XOR:  o_result = ^i_operand;
            OP_XNOR: o_result = ~^i_operand;
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/nary_gate_sweep.sv
// N-input gate with a direct registered path and a sweep engine that fills a
// 2**N-entry truth table, one operand value per cycle, through one evaluator.
module nary_gate_sweep
    import nary_gate_sweep_pkg::*;
#(
    parameter int N = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        op,
    input  logic              in_valid,
    input  logic [N-1:0]      in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic              out,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [2**N-1:0]   truth_table,
    output logic [N:0]        ones_count,
    output logic              err
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_op;
    logic [N-1:0]     r_index;
    logic [2**N-1:0]  r_tt;
    logic [N:0]       r_ones;
    logic             r_out;
    logic             r_out_valid;
    logic             r_err;

    logic             w_sweeping;
    logic [N-1:0]     w_operand;
    logic [2:0]       w_op;
    logic             w_result;
    logic             w_illegal;

    // The sweep borrows the evaluator; in IDLE it serves direct operands and
    // also screens the op presented alongside start.
    assign w_sweeping = (r_state == ST_SWEEP);
    assign w_operand  = w_sweeping ? r_index : in_data;
    assign w_op       = w_sweeping ? r_op    : op;

    gate_eval #(.N(N)) u_eval (
        .i_operand (w_operand),
        .i_op      (w_op),
        .o_result  (w_result),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SWEEP;
            ST_SWEEP: if (r_index == {N{1'b1}}) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_AND;
            r_index     <= '0;
            r_tt        <= '0;
            r_ones      <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_tt    <= '0;
                        r_ones  <= '0;
                        r_index <= '0;
                        if (w_illegal) r_err <= 1'b1;
                    end else if (in_valid) begin
                        r_out       <= w_result;
                        r_out_valid <= 1'b1;
                        if (w_illegal) r_err <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    r_tt[r_index] <= w_result;
                    r_ones        <= r_ones + (N+1)'(w_result);
                    r_index       <= r_index + N'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE) && !start;
    assign busy        = (r_state != ST_IDLE);
    assign done        = (r_state == ST_DONE);
    assign out         = r_out;
    assign out_valid   = r_out_valid;
    assign truth_table = r_tt;
    assign ones_count  = r_ones;
    assign err         = r_err;

endmodule

// File: doc/nary_gate_sweep.md
NARY_GATE_SWEEP -- requirements
Module: nary_gate_sweep

Interface
REQ-001 SHALL have parameter N, default 3, number of gate inputs, legal range 2..8.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port op, input, 3, gate function: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6..7 illegal.
REQ-005 SHALL have port in_valid, input, 1, direct-mode operand strobe.
REQ-006 SHALL have port in_data, input, N, direct-mode operands, bit k = input k.
REQ-007 SHALL have port in_ready, output, 1, high when direct operands are accepted.
REQ-008 SHALL have port out_valid, output, 1, one-cycle pulse qualifying out.
REQ-009 SHALL have port out, output, 1, registered gate result.
REQ-010 SHALL have port start, input, 1, sweep request pulse.
REQ-011 SHALL have port busy, output, 1, sweep in progress.
REQ-012 SHALL have port done, output, 1, one-cycle sweep-complete pulse.
REQ-013 SHALL have port truth_table, output, 2**N, bit i = gate result for operand value i.
REQ-014 SHALL have port ones_count, output, N+1, number of 1 bits in truth_table.
REQ-015 SHALL have port err, output, 1, sticky illegal-op flag.

Function
REQ-016 SHALL implement FSM states IDLE, SWEEP and DONE.
REQ-017 IDLE: in_ready=1; in_valid=1 registers f(op,in_data) into out, with out_valid=1 on the next cycle (latency 1).
REQ-018 IDLE: start=1 latches op, clears truth_table and ones_count, zeroes the N-bit index counter, and moves to SWEEP.
REQ-019 IDLE: if start and in_valid coincide, start wins and the operand is dropped (in_ready already reads 0 that cycle).
REQ-020 SWEEP: each cycle SHALL evaluate f(latched op, index), write it into truth_table[index], add it to ones_count, then increment index.
REQ-021 SWEEP: after index 2**N-1 is evaluated, SHALL go to DONE; index wraps to 0 and never overruns.
REQ-022 DONE: SHALL assert done for exactly one cycle, then return to IDLE; truth_table and ones_count hold until the next start.
REQ-023 Latency from the start edge to the done-high cycle SHALL be exactly 2**N+1 cycles.
REQ-024 busy=1 in SWEEP and DONE; in_ready=0, and start and in_valid are ignored while busy.
REQ-025 A change of op during a sweep SHALL not affect the sweep.
REQ-026 An illegal op SHALL evaluate to 0 and set err, both for direct acceptance and for start; err clears only on reset.
REQ-027 XOR/XNOR SHALL be N-input odd/even parity; AND/OR and their inversions SHALL be reductions over all N bits.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, with out=0, out_valid=0, busy=0, done=0, err=0, truth_table=0, ones_count=0, index=0.
REQ-029 Reset mid-sweep SHALL abort without a done pulse; the first start after release SHALL perform a complete sweep.

Structure
REQ-030 A shared package SHALL hold the 3-bit op encodings, the FSM state enum and the N range limits.
REQ-031 One sub-module, gate_eval (combinational: N-bit operand plus op gives 1-bit result plus illegal flag), SHALL be shared by the direct and sweep paths.

Verification
REQ-032 Test: N=3, op=NAND, start -> done at cycle 9, truth_table=8'h7F, ones_count=7.
REQ-033 Test: N=3, op=AND sweep -> truth_table=8'h80, ones_count=1; op=XOR sweep -> truth_table=8'h96, ones_count=4.
REQ-034 Test: direct op=NOR, in_data=3'b000, in_valid=1 -> next cycle out=1, out_valid=1; in_data=3'b010 -> out=0.
REQ-035 Test: start and in_valid in the same cycle, then start pulses during SWEEP -> exactly one sweep, no out_valid, one done.
REQ-036 Test: op=6 direct -> out=0, err=1 and err stays 1 afterwards; rst_n low at sweep index 4 -> all outputs 0 and no done.
REQ-037 Test: N=8, op=OR sweep -> done at cycle 257, truth_table bit 0 = 0 and all other bits 1, ones_count=255.
